// File: rtl/wb_pkg.sv
// Shared types, widths and helpers for the register-file write-back queue.
// The module parameters of wb_pack / wb_queue default to the constants below.
package wb_pkg;

  localparam int SRC_PORT   = 6;
  localparam int WRITE_PORT = 4;
  localparam int WIDTH      = 32;
  localparam int DEPTH      = 64;
  localparam int FIFO_DEPTH = 16;
  localparam int ADDR_W     = $clog2(DEPTH);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int MAX_SRC    = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } wb_entry_t;

  // Number of set bits in v strictly below index limit.
  function automatic int popcount_upto(input logic [MAX_SRC-1:0] v, input int limit);
    int n;
    n = 0;
    for (int i = 0; i < MAX_SRC; i++) begin
      if (i < limit && v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/wb_pack.sv
// Compacts valid, nonzero-address sources into dense slots 0..n_in-1,
// keeping source index order so slot 0 is always the oldest result.
module wb_pack
  import wb_pkg::*;
#(
  parameter  int Src_Port = SRC_PORT,
  localparam int NW       = $clog2(Src_Port + 1)
) (
  input  logic              valid_i [Src_Port],
  input  logic [ADDR_W-1:0] addr_i  [Src_Port],
  input  logic [WIDTH-1:0]  data_i  [Src_Port],
  output wb_entry_t         slot_o  [Src_Port],
  output logic [NW-1:0]     n_in_o
);

  logic [MAX_SRC-1:0] elig;

  // Register 0 is hard-wired to zero, so writes to it are dropped here.
  always_comb begin
    elig = '0;
    for (int i = 0; i < Src_Port; i++) begin
      elig[i] = valid_i[i] && (addr_i[i] != '0);
    end
  end

  always_comb begin
    for (int j = 0; j < Src_Port; j++) begin
      slot_o[j] = '0;
      for (int i = j; i < Src_Port; i++) begin
        if (elig[i] && popcount_upto(elig, i) == j) begin
          slot_o[j] = '{addr: addr_i[i], data: data_i[i]};
        end
      end
    end
  end

  assign n_in_o = NW'(popcount_upto(elig, Src_Port));

endmodule

// File: rtl/wb_queue.sv
// Age-ordered circular write-back buffer: up to Src_Port results in per cycle,
// up to Write_Port oldest entries out per cycle, plus a per-register pending map.
module wb_queue
  import wb_pkg::*;
#(
  parameter  int Src_Port   = SRC_PORT,
  parameter  int Write_Port = WRITE_PORT,
  parameter  int Width      = WIDTH,
  parameter  int Depth      = DEPTH,
  parameter  int Fifo_Depth = FIFO_DEPTH,
  localparam int AW         = $clog2(Depth),
  localparam int PW         = $clog2(Fifo_Depth),
  localparam int CW         = $clog2(Fifo_Depth + 1),
  localparam int NW         = $clog2(Src_Port + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid [Src_Port],
  input  logic [AW-1:0]    in_addr  [Src_Port],
  input  logic [Width-1:0] in_data  [Src_Port],
  output logic             in_ready,
  output logic             We [Write_Port],
  output logic [AW-1:0]    WA [Write_Port],
  output logic [Width-1:0] WD [Write_Port],
  output logic [Depth-1:0] pend,
  output logic [CW-1:0]    count
);

  wb_entry_t     mem_q [Fifo_Depth];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] n_push, n_out;
  logic [NW-1:0] n_in;
  wb_entry_t     slot [Src_Port];
  logic [PW-1:0] off;

  wb_pack #(.Src_Port(Src_Port)) u_pack (
    .valid_i (in_valid),
    .addr_i  (in_addr),
    .data_i  (in_data),
    .slot_o  (slot),
    .n_in_o  (n_in)
  );

  // Ready looks only at the registered count, so it ignores this cycle's drain.
  assign in_ready = (Fifo_Depth - int'(count_q)) >= Src_Port;
  assign n_push   = in_ready ? CW'(n_in) : '0;
  assign n_out    = (int'(count_q) < Write_Port) ? count_q : CW'(Write_Port);
  assign count    = count_q;

  always_comb begin
    head_d  = head_q + PW'(n_out);
    tail_d  = tail_q + PW'(n_push);
    count_d = count_q + n_push - n_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < Src_Port; j++) begin
      if (CW'(j) < n_push) mem_q[tail_q + PW'(j)] <= slot[j];
    end
  end

  always_comb begin
    for (int k = 0; k < Write_Port; k++) begin
      We[k] = CW'(k) < n_out;
      WA[k] = mem_q[head_q + PW'(k)].addr;
      WD[k] = mem_q[head_q + PW'(k)].data;
    end
  end

  // An entry is occupied when its distance from head is below count.
  always_comb begin
    pend = '0;
    off  = '0;
    for (int e = 0; e < Fifo_Depth; e++) begin
      off = PW'(e) - head_q;
      if ({1'b0, off} < count_q) pend[mem_q[e].addr] = 1'b1;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    int'(count_q) <= Fifo_Depth);
  a_no_push_unready: assert property (@(posedge clk) disable iff (!rst_n)
    !in_ready |-> (n_push == '0));

endmodule

// File: tb/tb_wb_queue.sv
// Randomized and directed bench for wb_queue with a queue-based reference model
// and a negedge monitor that compares every drain cycle against it.
module tb_wb_queue;

  logic        clk;
  logic        rst_n;
  logic        in_valid [6];
  logic [5:0]  in_addr  [6];
  logic [31:0] in_data  [6];
  logic        in_ready;
  logic        We [4];
  logic [5:0]  WA [4];
  logic [31:0] WD [4];
  logic [63:0] pend;
  logic [4:0]  count;

  wb_queue dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .in_ready (in_ready),
    .We       (We),
    .WA       (WA),
    .WD       (WD),
    .pend     (pend),
    .count    (count)
  );

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] rf_exp [64];
  logic [31:0] rf_dut [64];
  int          checks;
  int          failures;
  bit          lacc;
  bit          lv [6];
  logic [5:0]  la [6];
  logic [31:0] ld [6];
  bit          saw_full;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: model occupancy, ready, pending map and drain ports every cycle.
  always @(negedge clk) begin
    int n;
    logic [63:0] pm;
    n  = (sbq.size() < 4) ? sbq.size() : 4;
    pm = '0;
    foreach (sbq[i]) pm[sbq[i].a] = 1'b1;
    chk("count", 64'(count), 64'(sbq.size()));
    chk("in_ready", 64'(in_ready), 64'((16 - sbq.size()) >= 6));
    chk("pend", pend, pm);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("we%0d", k), 64'(We[k]), 64'(k < n));
      if (k < n) begin
        chk($sformatf("wa%0d", k), 64'(WA[k]), 64'(sbq[k].a));
        chk($sformatf("wd%0d", k), 64'(WD[k]), 64'(sbq[k].d));
        rf_exp[sbq[k].a] = sbq[k].d;
      end
      if (We[k] && rst_n) begin
        if (WA[k] == 6'd0) chk("write_to_r0", 64'(WA[k]), 64'd1);
        rf_dut[WA[k]] = WD[k];
      end
    end
    for (int k = 0; k < n; k++) void'(sbq.pop_front());
  end

  task automatic clear_src();
    for (int i = 0; i < 6; i++) begin
      in_valid[i] = 1'b0;
      in_addr[i]  = 6'd0;
      in_data[i]  = 32'd0;
    end
  endtask

  task automatic set_src(input int i, input int a, input logic [31:0] d);
    in_valid[i] = 1'b1;
    in_addr[i]  = 6'(a);
    in_data[i]  = d;
  endtask

  // Capture what is driven, let one edge pass, then record accepted results.
  task automatic step();
    lacc = in_ready;
    for (int i = 0; i < 6; i++) begin
      lv[i] = in_valid[i];
      la[i] = in_addr[i];
      ld[i] = in_data[i];
    end
    @(posedge clk);
    #2;
    if (lacc) begin
      for (int i = 0; i < 6; i++) begin
        if (lv[i] && la[i] != 6'd0) sbq.push_back('{a: la[i], d: ld[i]});
      end
    end
    $display("cycle t=%0t count=%0d in_ready=%0d pend=0x%0h", $time, count, in_ready, pend);
  endtask

  task automatic idle(input int n);
    clear_src();
    repeat (n) step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    lacc     = 1'b0;
    saw_full = 1'b0;
    foreach (rf_exp[r]) begin
      rf_exp[r] = '0;
      rf_dut[r] = '0;
    end
    clear_src();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_pend", pend, 64'd0);
    for (int k = 0; k < 4; k++) chk("rst_we", 64'(We[k]), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Single result: one-cycle latency, then gone.
    clear_src();
    set_src(0, 5, 32'hDEADBEEF);
    step();
    chk("single_we0", 64'(We[0]), 64'd1);
    chk("single_wa0", 64'(WA[0]), 64'd5);
    chk("single_wd0", 64'(WD[0]), 64'hDEADBEEF);
    chk("single_pend5", 64'(pend[5]), 64'd1);
    idle(1);
    chk("single_count_after", 64'(count), 64'd0);
    chk("single_pend5_after", 64'(pend[5]), 64'd0);

    // Six sources at once drain as 4 then 2.
    clear_src();
    for (int i = 0; i < 6; i++) set_src(i, i + 1, $urandom);
    step();
    chk("six_count", 64'(count), 64'd6);
    for (int k = 0; k < 4; k++) chk("six_wa_first", 64'(WA[k]), 64'(k + 1));
    idle(1);
    chk("six_count2", 64'(count), 64'd2);
    chk("six_wa_second0", 64'(WA[0]), 64'd5);
    chk("six_wa_second1", 64'(WA[1]), 64'd6);
    chk("six_we2_off", 64'(We[2]), 64'd0);
    idle(1);
    chk("six_count3", 64'(count), 64'd0);

    // Same address twice in one cycle: youngest (src3) wins.
    clear_src();
    set_src(0, 7, 32'h1);
    set_src(3, 7, 32'h2);
    step();
    chk("same_we0", 64'(We[0]), 64'd1);
    chk("same_we1", 64'(We[1]), 64'd1);
    chk("same_wa1", 64'(WA[1]), 64'd7);
    idle(1);
    chk("same_final_r7", 64'(rf_dut[7]), 64'h2);

    // Register 0 target is accepted but not queued.
    clear_src();
    for (int i = 0; i < 6; i++) set_src(i, i + 10, $urandom);
    in_addr[2] = 6'd0;
    step();
    chk("r0_count", 64'(count), 64'd5);
    idle(3);

    // Reset while draining five entries.
    clear_src();
    for (int i = 0; i < 5; i++) set_src(i, 20 + i, $urandom);
    step();
    chk("mid_count_before", 64'(count), 64'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_count", 64'(count), 64'd0);
    chk("mid_pend", pend, 64'd0);
    chk("mid_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 4; k++) chk("mid_we", 64'(We[k]), 64'd0);
    sbq.delete();
    clear_src();
    step();
    rst_n = 1'b1;
    idle(1);

    // Random traffic; sources hold their result while not ready.
    for (int c = 0; c < 200; c++) begin
      if (in_ready) begin
        clear_src();
        for (int i = 0; i < 6; i++) begin
          if ($urandom_range(0, 3) != 0) set_src(i, $urandom_range(0, 63), $urandom);
        end
      end
      step();
      if (count > 5'd10) saw_full = 1'b1;
    end
    chk("reached_above_10", 64'(saw_full), 64'd1);

    clear_src();
    for (int c = 0; c < 20 && sbq.size() != 0; c++) step();
    step();
    chk("drained_model", 64'(sbq.size()), 64'd0);
    chk("drained_count", 64'(count), 64'd0);
    for (int r = 0; r < 64; r++) chk($sformatf("rf%0d", r), 64'(rf_dut[r]), 64'(rf_exp[r]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-back buffer directly upstream of the multi-ported register file.
- Collects results from up to Src_Port execution units per cycle and stores them in age order in a circular FIFO.
- Drains up to Write_Port oldest entries per cycle onto the register file write ports (We/WA/WD).
- Exports a per-register pending vector so operand-read logic can detect writes that are still queued.

Parameters:
- Src_Port, 6, number of result sources presented per cycle.
- Write_Port, 4, number of register file write ports driven.
- Width, 32, data width.
- Depth, 64, register count; address width is $clog2(Depth).
- Fifo_Depth, 16, number of queue entries. Must be a power of two and >= Src_Port.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid[Src_Port]  input  1 each  source i presents a result.
- in_addr[Src_Port]  input  $clog2(Depth) each  destination register.
- in_data[Src_Port]  input  Width each  result data.
- in_ready  output  1  queue accepts all presented sources this cycle.
- We[Write_Port]  output  1 each  write enables to the register file.
- WA[Write_Port]  output  $clog2(Depth) each  write addresses.
- WD[Write_Port]  output  Width each  write data.
- pend  output  Depth  bit r is 1 while any queued entry targets r.
- count  output  $clog2(Fifo_Depth+1)  current occupancy.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - head, tail and count clear to 0.
  - All We = 0, pend = 0, in_ready = 1.
  - Entry storage is not reset.
  - Reset asserted mid-operation discards all queued entries immediately; no write is issued afterwards.
- in_ready:
  - Defined as (Fifo_Depth - count) >= Src_Port.
  - Depends only on registered count, never on in_valid.
  - All-or-nothing: sources sample in_ready and hold their result while it is 0.
- Enqueue (in_valid[i] && in_ready):
  - Accepted sources are packed in index order (lowest index = oldest) starting at tail.
  - tail advances by the number of enqueued entries, modulo Fifo_Depth.
  - A source with in_addr==0 is accepted but not enqueued and consumes no slot, because register 0 reads as zero.
- Drain:
  - n_out = min(count, Write_Port).
  - Port k (k < n_out) drives the entry at head+k: We[k]=1 with its WA/WD. Ports k >= n_out drive We[k]=0.
  - Outputs come from entry flops and are purely combinational from head and count; the register file writes them on the same edge.
  - head advances by n_out on that edge.
  - Latency: a result accepted on edge N appears on We/WA/WD in cycle N+1 if fewer than Write_Port older entries are queued.
- Simultaneous enqueue and drain in one cycle:
  - count_next = count + n_in - n_out.
  - in_ready uses the pre-pop count, which is conservative.
- Same-address writes in one drain cycle:
  - Port order equals age order.
  - The register file applies writes in ascending port index, so the youngest write wins. This is the required semantics.
- pend:
  - OR over all occupied entries of the one-hot of their addresses.
  - Entries being drained in the current cycle still count as pending.
- Pointer wrap:
  - Pointers are $clog2(Fifo_Depth) bits and wrap naturally.
  - count disambiguates full from empty.
- Overflow cannot occur by construction.
  - Assertion: count <= Fifo_Depth.
  - Assertion: no enqueue while in_ready==0.

Decomposition:
- Package wb_pkg:
  - typedef wb_entry_t {addr, data}.
  - localparams ADDR_W and PTR_W.
  - Function popcount_upto(valid vector, limit).
- One sub-module, wb_pack: combinational compaction of valid nonzero-address sources into dense slots 0..n_in-1, with n_in output.
- The FIFO pointers, storage and pend generation stay in wb_queue.

Test Plan:
- Reset then idle: count=0, all We=0, pend=0, in_ready=1. Assert rst_n low mid-drain with count=5 -> same cycle count=0 and We all 0.
- Single result src0 addr=5 data=0xDEADBEEF -> next cycle We[0]=1, WA[0]=5, WD[0]=0xDEADBEEF, pend[5]=1. The following cycle count=0 and pend[5]=0.
- All 6 sources valid, addrs 1..6, empty queue -> cycle+1 ports 0..3 write addrs 1..4, cycle+2 ports 0..1 write addrs 5..6, count goes 6 -> 2 -> 0.
- Fill to count=11 with continuous traffic -> in_ready=0 while count>10. No entries lost or reordered over 200 random cycles; scoreboard checks write order against source order.
- Sources 0 and 3 both target addr 7 (data 0x1, 0x2) in one cycle -> both drain the same cycle on ports 0 and 1; final register value 0x2.
- in_addr=0 on src2 with others valid -> src2 is not enqueued, count increases by 5, no write to register 0 is ever issued.
